// File: rtl/phy_pkg.sv
// Shared PHY definitions: symbol width, default framing symbols and the
// framer state encoding used on both TX and RX sides of the lane.
package phy_pkg;

  localparam int SYMBOL_W = 8;

  localparam logic [SYMBOL_W-1:0] COM_SYM_DEF  = 8'hBC;
  localparam logic [SYMBOL_W-1:0] IDLE_SYM_DEF = 8'h7C;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ps_shift8.sv
// 8-bit load/shift register with its bit counter; loads sym_in when the
// counter sits at 7, otherwise shifts left MSB-first with zero fill.
module ps_shift8
  import phy_pkg::*;
(
  input  logic                clk_32f,
  input  logic                reset,
  input  logic [SYMBOL_W-1:0] sym_in,
  output logic                load_en,
  output logic                ser_out
);

  logic [SYMBOL_W-1:0] shift_reg;
  logic [SYMBOL_W-1:0] shift_next;
  logic [2:0]          bit_cnt_reg;

  assign shift_next[0] = 1'b0;
  for (genvar gi = 0; gi < SYMBOL_W - 1; gi++) begin : g_shift
    assign shift_next[gi+1] = shift_reg[gi];
  end

  assign load_en = (bit_cnt_reg == 3'd7);
  assign ser_out = shift_reg[SYMBOL_W-1];

  // bit_cnt resets to 7 so the very first edge after reset loads a symbol
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= 3'd7;
    end else if (load_en) begin
      shift_reg   <= sym_in;
      bit_cnt_reg <= 3'd0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

endmodule

// File: rtl/paralelo_serial_framer.sv
// TX lane framer: COM lock sequence after reset, then data or IDLE fill.
// Optional periodic COM re-lock insertion is enabled with SKIP_INSERT_EN.
module paralelo_serial_framer
  import phy_pkg::*;
#(
  parameter int                  COM_COUNT     = 4,
  parameter logic [SYMBOL_W-1:0] COM_SYM       = COM_SYM_DEF,
  parameter logic [SYMBOL_W-1:0] IDLE_SYM      = IDLE_SYM_DEF,
  parameter int                  SKIP_INTERVAL = 64
) (
  input  logic                clk_32f,
  input  logic                reset,
  input  logic [SYMBOL_W-1:0] data_in,
  input  logic                valid_in,
  output logic                byte_req,
  output logic                data_paralelo_serial,
  output logic                active_out
);

  if (COM_COUNT < 1 || COM_COUNT > 15) begin : g_bad_com_count
    $error("paralelo_serial_framer: COM_COUNT must be 1..15");
  end
  if (SKIP_INTERVAL < 2 || SKIP_INTERVAL > 255) begin : g_bad_skip_interval
    $error("paralelo_serial_framer: SKIP_INTERVAL must be 2..255");
  end

  localparam logic [3:0] COM_LAST = 4'(COM_COUNT - 1);

  state_t              state_reg, state_next;
  logic [3:0]          com_cnt_reg, com_cnt_next;
  logic [SYMBOL_W-1:0] sym_in;
  logic                load_en;
  logic                skip_now;

  ps_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .sym_in  (sym_in),
    .load_en (load_en),
    .ser_out (data_paralelo_serial)
  );

`ifdef SKIP_INSERT_EN
  localparam logic [7:0] SKIP_LAST = 8'(SKIP_INTERVAL - 1);

  logic [7:0] sym_cnt_reg, sym_cnt_next;

  // skip_now marks a load slot that is stolen for a re-lock COM
  assign skip_now = (state_reg == RUN) && (sym_cnt_reg == SKIP_LAST);

  always_comb begin
    sym_cnt_next = sym_cnt_reg;
    if (load_en && (state_reg == RUN)) begin
      sym_cnt_next = skip_now ? 8'd0 : sym_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sym_cnt_reg <= 8'd0;
    end else begin
      sym_cnt_reg <= sym_cnt_next;
    end
  end
`else
  assign skip_now = 1'b0;
`endif

  assign active_out = (state_reg == RUN);
  assign byte_req   = (state_reg == RUN) && load_en && !skip_now;

  always_comb begin
    state_next   = state_reg;
    com_cnt_next = com_cnt_reg;
    sym_in       = IDLE_SYM;
    case (state_reg)
      SYNC: begin
        sym_in = COM_SYM;
        if (load_en) begin
          com_cnt_next = com_cnt_reg + 4'd1;
          if (com_cnt_reg == COM_LAST) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (skip_now) begin
          sym_in = COM_SYM;
        end else if (valid_in) begin
          sym_in = data_in;
        end else begin
          sym_in = IDLE_SYM;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_reg   <= SYNC;
      com_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      com_cnt_reg <= com_cnt_next;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_framer.sv
// Directed bench for paralelo_serial_framer; each symbol window of 8 bit
// times is sampled on the falling edge and compared to hand-derived values.
module tb_paralelo_serial_framer;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       byte_req;
  logic       data_paralelo_serial;
  logic       active_out;

  int errors = 0;
  int checks = 0;
  logic lock_last_req;

  paralelo_serial_framer #(
    .COM_COUNT     (4),
    .COM_SYM       (8'hBC),
    .IDLE_SYM      (8'h7C),
    .SKIP_INTERVAL (4)
  ) dut (
    .clk_32f              (clk_32f),
    .reset                (reset),
    .data_in              (data_in),
    .valid_in             (valid_in),
    .byte_req             (byte_req),
    .data_paralelo_serial (data_paralelo_serial),
    .active_out           (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer (v,d) for the load edge opening this window, then sample 8 bit times.
  task automatic run_window(input logic v, input logic [7:0] d, input bit glitch,
                            output logic [7:0] sym, output int reqs,
                            output logic last_req, output logic first_active);
    valid_in = v;
    data_in  = d;
    sym = 8'h00; reqs = 0; last_req = 1'b0; first_active = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_32f);
      sym = {sym[6:0], data_paralelo_serial};
      if (byte_req === 1'b1) reqs++;
      if (i == 0) first_active = active_out;
      if (i == 7) last_req = byte_req;
      if (glitch && i == 2) begin data_in = 8'h55; valid_in = 1'b1; end
      if (glitch && i == 4) begin data_in = d;     valid_in = v;    end
    end
    $display("window: offered v=%0b d=%02h -> sym=%02h reqs=%0d active=%0b", v, d, sym, reqs, first_active);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk_32f);
    checks++;
    if (data_paralelo_serial !== 1'b0) begin errors++; $display("FAIL reset_line: got %b want 0", data_paralelo_serial); end
    checks++;
    if (active_out !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active_out); end
    checks++;
    if (byte_req !== 1'b0) begin errors++; $display("FAIL reset_byte_req: got %b want 0", byte_req); end
    reset = 1'b1;
  endtask

  // Called right after reset release; upstream offer must be ignored in SYNC.
  task automatic test_lock(input logic v, input logic [7:0] d);
    logic [7:0] sym; int reqs; logic last_req, act;
    for (int w = 0; w < 4; w++) begin
      run_window(v, d, 1'b0, sym, reqs, last_req, act);
      checks++;
      if (sym !== 8'hBC) begin errors++; $display("FAIL lock_sym%0d: got %02h want bc", w, sym); end
      checks++;
      if (reqs != ((w == 3) ? 1 : 0)) begin errors++; $display("FAIL lock_req%0d: got %0d want %0d", w, reqs, (w == 3) ? 1 : 0); end
      checks++;
      if (act !== ((w == 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL lock_active%0d: got %b want %b", w, act, (w == 3)); end
      lock_last_req = last_req;
    end
    checks++;
    if (lock_last_req !== 1'b1) begin errors++; $display("FAIL first_req_cycle31: got %b want 1", lock_last_req); end
  endtask

  task automatic test_idle();
    logic [7:0] sym; int reqs; logic last_req, act;
    run_window(1'b0, 8'h00, 1'b0, sym, reqs, last_req, act);
    checks++;
    if (sym !== 8'h7C) begin errors++; $display("FAIL idle_sym: got %02h want 7c", sym); end
    checks++;
    if (reqs != 1 || last_req !== 1'b1) begin errors++; $display("FAIL idle_req: got %0d want 1", reqs); end
    checks++;
    if (act !== 1'b1) begin errors++; $display("FAIL idle_active: got %b want 1", act); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] sym; int reqs; logic last_req, act;
    for (int i = 0; i < 3; i++) begin
      run_window(1'b1, vec[i], 1'b0, sym, reqs, last_req, act);
      checks++;
      if (sym !== vec[i]) begin errors++; $display("FAIL b2b_sym%0d: got %02h want %02h", i, sym, vec[i]); end
      checks++;
      if (reqs != 1) begin errors++; $display("FAIL b2b_req%0d: got %0d want 1", i, reqs); end
    end
  endtask

  task automatic test_valid_toggle();
    logic       vv  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] dd  [3] = '{8'h11, 8'h99, 8'h22};
    logic [7:0] exp [3] = '{8'h11, 8'h7C, 8'h22};
    logic [7:0] sym; int reqs; logic last_req, act;
    for (int i = 0; i < 3; i++) begin
      run_window(vv[i], dd[i], 1'b0, sym, reqs, last_req, act);
      checks++;
      if (sym !== exp[i]) begin errors++; $display("FAIL toggle_sym%0d: got %02h want %02h", i, sym, exp[i]); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] sym; int reqs; logic last_req, act;
    run_window(1'b0, 8'h00, 1'b1, sym, reqs, last_req, act);
    checks++;
    if (sym !== 8'h7C) begin errors++; $display("FAIL glitch_sym: got %02h want 7c", sym); end
    run_window(1'b1, 8'h5A, 1'b0, sym, reqs, last_req, act);
    checks++;
    if (sym !== 8'h5A) begin errors++; $display("FAIL glitch_next_sym: got %02h want 5a", sym); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] part;
    logic [7:0] sym; int reqs; logic last_req, act;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    part = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_32f);
      part = {part[2:0], data_paralelo_serial};
    end
    checks++;
    if (part !== 4'b1010) begin errors++; $display("FAIL mid_partial: got %b want 1010", part); end
    reset = 1'b0;
    #1;
    checks++;
    if (data_paralelo_serial !== 1'b0) begin errors++; $display("FAIL mid_line: got %b want 0", data_paralelo_serial); end
    checks++;
    if (byte_req !== 1'b0 || active_out !== 1'b0) begin errors++; $display("FAIL mid_req_active: got %b%b want 00", byte_req, active_out); end
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    $display("reset pulse mid-symbol done");
    test_lock(1'b1, 8'hA5);
    run_window(1'b1, 8'hC3, 1'b0, sym, reqs, last_req, act);
    checks++;
    if (sym !== 8'hC3) begin errors++; $display("FAIL mid_relock_data: got %02h want c3", sym); end
  endtask

`ifdef SKIP_INSERT_EN
  task automatic test_skip();
    logic [7:0] src [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'hBC, 8'h04, 8'h05, 8'h06, 8'hBC};
    logic       ereq [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] sym; int reqs; logic last_req, act;
    int ptr;
    logic prev_req;
    ptr = 0;
    prev_req = lock_last_req;
    for (int w = 0; w < 8; w++) begin
      run_window(1'b1, src[ptr], 1'b0, sym, reqs, last_req, act);
      checks++;
      if (sym !== exp[w]) begin errors++; $display("FAIL skip_sym%0d: got %02h want %02h", w, sym, exp[w]); end
      checks++;
      if (last_req !== ereq[w]) begin errors++; $display("FAIL skip_req%0d: got %b want %b", w, last_req, ereq[w]); end
      if (prev_req === 1'b1) ptr++;
      prev_req = last_req;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock(1'b0, 8'h00);
`ifdef SKIP_INSERT_EN
    test_skip();
`else
    test_idle();
    test_back_to_back();
    test_valid_toggle();
    test_glitch();
    test_reset_mid();
    test_idle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_framer.md
Name: paralelo_serial_framer

Overview:
TX-side serializer that directly feeds the serial_paralelo receiver input (data_paralelo_serial_*) of phy_RX.
- Accepts one 8-bit byte per 8 clk_32f cycles from the upstream byte-striping/demux logic.
- Frames the link with COM (0xBC) lock symbols after reset and IDLE (0x7C) fill symbols when no valid byte is offered.
- Shifts each symbol out MSB-first on a single-bit line.
- One instance per lane.

Parameters:
COM_COUNT, 4, number of COM symbols sent after reset before data is accepted (receiver needs 4 to assert active); legal 1..15
COM_SYM, 8'hBC, comma/lock symbol
IDLE_SYM, 8'h7C, fill symbol sent when no valid byte is sampled
SKIP_INTERVAL, 64, symbols between inserted COMs (used only with SKIP_INSERT_EN); legal 2..255

Ports:
clk_32f  input  1  bit clock; the only clock of the block
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_in  input  8  byte offered by upstream
valid_in  input  1  data_in holds a real byte
byte_req  output  1  load strobe, decoded from registers only; upstream byte is consumed on the clk_32f edge where byte_req=1
data_paralelo_serial  output  1  serial line, MSB-first
active_out  output  1  1 once the COM lock sequence is complete (state RUN)

Behaviour:
- Reset (reset=0, async) forces:
  - shift reg = 0 and data_paralelo_serial = 0 (it is shift reg bit 7, a flop);
  - bit_cnt = 7, com_cnt = 0, state = SYNC;
  - byte_req = 0, active_out = 0.
- bit_cnt (3 bits) advances 0..7 and wraps. On the edge with bit_cnt = 7, the next symbol is loaded into the shift reg and bit_cnt becomes 0. On all other edges the shift reg shifts left by 1 with zero fill.
- First edge after reset release loads a symbol; its MSB appears on the line immediately after that edge. Bit k of a symbol is driven k cycles after load.
- States (2-state FSM):
  - SYNC: each load picks COM_SYM and increments com_cnt. The load that makes com_cnt = COM_COUNT also moves state to RUN on that edge. No upstream byte is ever consumed in SYNC.
  - RUN: active_out = 1. byte_req = 1 exactly when bit_cnt = 7 (1 cycle in 8). On that edge the load is data_in if valid_in = 1, otherwise IDLE_SYM. valid_in/data_in are ignored when byte_req = 0.
- Output latency: a byte sampled at edge E has its MSB on the line after E and its LSB after E+7.
- Throughput: max 1 byte per 8 cycles, with no back-pressure beyond byte_req.
- First data slot: the first byte_req pulse occurs 8*COM_COUNT-1 cycles after the first post-reset edge (cycle 31 for COM_COUNT = 4).
- Upstream values equal to COM_SYM/IDLE_SYM are passed through unchanged; framing is the upstream's responsibility.
- Reset asserted mid-symbol: the partial symbol is truncated, the line goes to 0 at once, and the lock sequence restarts.
- The block never returns from RUN to SYNC except through reset.

Optional Feature:
SKIP_INSERT_EN
- Defined:
  - An 8-bit symbol counter counts loads in RUN.
  - When it reaches SKIP_INTERVAL-1, the next load is forced to COM_SYM, the counter clears, and byte_req stays 0 for that slot, so upstream holds its byte.
  - This periodic re-lock lets the receiver recover alignment.
- Undefined: no counter, no inserted COMs; byte_req pulses every 8 cycles in RUN.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYM/IDLE_SYM default constants (also used by serial_paralelo);
  - state typedef {SYNC, RUN};
  - SYMBOL_W = 8.
- One natural sub-module: ps_shift8. It contains the 8-bit load/shift register plus bit_cnt and exposes load_en (bit_cnt = 7), sym_in and ser_out. The FSM and symbol muxing stay in the top.

Test Plan:
- Reset release, valid_in = 0, COM_COUNT = 4 -> 32 cycles of 10111100 repeated ×4; active_out rises at the 4th COM load; then 01111100 repeated; first byte_req at cycle 31.
- RUN, valid_in = 1 with bytes 0xA5, 0x3C, 0xFF on consecutive byte_req pulses -> line shows 10100101 00111100 11111111 back-to-back; byte_req pulses every 8 cycles.
- valid_in toggling 1,0,1 across slots with 0x11, x, 0x22 -> 00010001 01111100 00100010.
- Reset asserted at bit 3 of a data byte -> line 0 within the same cycle, no byte_req; after release, 4 COMs again before data.
- data_in/valid_in changing while byte_req = 0 (e.g. 0x55 pulsed mid-symbol) -> no effect on the line.
- SKIP_INSERT_EN, SKIP_INTERVAL = 4, continuous valid data 0x01..0x06 -> 0x01 0x02 0x03 COM 0x04 0x05 0x06 COM; byte_req absent in the COM slots, no byte lost.
